// File: rtl/dma_pkg.sv
// Shared types for the multichannel DMA datapath: global register offsets,
// channel mode layout and the byte-pointer span helper.
package dma_pkg;

    typedef enum logic [2:0] {
        OFS_CMD     = 3'd0,
        OFS_REQ     = 3'd1,
        OFS_MASK1   = 3'd2,
        OFS_MODE    = 3'd3,
        OFS_CLRPTR  = 3'd4,
        OFS_MCLR    = 3'd5,
        OFS_CLRMASK = 3'd6,
        OFS_ALLMASK = 3'd7
    } regOfs_e;

    // Field order gives autoInit at bit 2 and decrement at bit 3 of the 6-bit mode.
    typedef struct packed {
        logic [1:0] modeSel;
        logic       decrement;
        logic       autoInit;
        logic [1:0] xferType;
    } mode_t;

    function automatic int numBytes(input int addrW, input int cntW);
        return ((addrW > cntW) ? addrW : cntW) / 8;
    endfunction

endpackage

// File: rtl/dma_chan_regs.sv
// One channel's base/current address and count plus its mode byte.
// Byte writes load base and current together; reload and write-back take effect next edge.
module dma_chan_regs
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrAddr,
    input  logic              wrCnt,
    input  logic [1:0]        bytePtr,
    input  logic [7:0]        wrData,
    input  logic              wrMode,
    input  mode_t             modeIn,
    input  logic              reload,
    input  logic              writeBack,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [CNT_W-1:0]  wbCnt,
    output logic [ADDR_W-1:0] curAddr,
    output logic [CNT_W-1:0]  curCnt,
    output mode_t             mode
);

    logic [ADDR_W-1:0] baseAddr;
    logic [CNT_W-1:0]  baseCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baseAddr <= '0;
            baseCnt  <= '0;
            curAddr  <= '0;
            curCnt   <= '0;
            mode     <= '0;
        end else begin
            if (wrMode) begin
                mode <= modeIn;
            end
            // Pointer positions past the register width simply match no byte lane.
            for (int b = 0; b < ADDR_W / 8; b++) begin
                if (wrAddr && bytePtr == 2'(b)) begin
                    baseAddr[b*8 +: 8] <= wrData;
                    curAddr[b*8 +: 8]  <= wrData;
                end
            end
            for (int b = 0; b < CNT_W / 8; b++) begin
                if (wrCnt && bytePtr == 2'(b)) begin
                    baseCnt[b*8 +: 8] <= wrData;
                    curCnt[b*8 +: 8]  <= wrData;
                end
            end
            if (reload) begin
                curAddr <= baseAddr;
                curCnt  <= baseCnt;
            end else if (writeBack) begin
                curAddr <= wbAddr;
                curCnt  <= wbCnt;
            end
        end
    end

endmodule

// File: rtl/dma_multichannel_datapath.sv
// Multichannel DMA register file and transfer datapath: CPU-side programming port,
// working address/count stepping with terminal count; single-cycle ops, no stalls.
module dma_multichannel_datapath
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16,
    parameter int PA_W   = $clog2(NUM_CH) + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      CS_N,
    input  logic                      IOR_N,
    input  logic                      IOW_N,
    input  logic [PA_W-1:0]           port_addr,
    input  logic [7:0]                data_i,
    output logic [7:0]                data_o,
    output logic                      data_oe,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic                      ld_work,
    input  logic                      step,
    input  logic                      end_xfer,
    input  logic [NUM_CH-1:0]         dreq,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      tc,
    output logic [5:0]                mode_o,
    output logic [NUM_CH-1:0]         mask_o,
    output logic [NUM_CH-1:0]         req_o,
    output logic                      rot_prio
);

    localparam int CW  = $clog2(NUM_CH);
    localparam int NB  = numBytes(ADDR_W, CNT_W);
    localparam int LIM = (NUM_CH < 4) ? NUM_CH : 4;

    logic              regWr, regRd, isGlobal, isCnt, chValid, chanAccess, mclr;
    logic              ldEn, stepEn, endEn, tcHit;
    logic [CW-1:0]     chIdx, dataChan;
    regOfs_e           ofs;
    logic [1:0]        bytePtr;
    logic [NUM_CH-1:0] tcFlags;
    logic [7:0]        statusByte;
    logic [ADDR_W-1:0] workAddr, workAddrNext, wbAddr;
    logic [CNT_W-1:0]  workCnt, wbCnt;
    mode_t             selMode;
    logic [ADDR_W-1:0] curAddr [NUM_CH];
    logic [CNT_W-1:0]  curCnt  [NUM_CH];
    mode_t             curMode [NUM_CH];

    assign regWr      = !CS_N && !IOW_N;
    assign regRd      = !CS_N && !IOR_N && IOW_N;
    assign isGlobal   = port_addr[PA_W-1];
    assign chIdx      = port_addr[PA_W-2:1];
    assign isCnt      = port_addr[0];
    assign ofs        = regOfs_e'(port_addr[2:0]);
    assign chValid    = 32'(chIdx) < NUM_CH;
    assign chanAccess = (regWr || regRd) && !isGlobal;
    assign mclr       = regWr && isGlobal && (ofs == OFS_MCLR);
    // With eight channels bit 3 extends the channel field beyond bits 1:0.
    assign dataChan   = CW'({data_i[3], data_i[1:0]});

    assign ldEn   = CS_N && ld_work;
    assign stepEn = CS_N && !ld_work && step;
    assign endEn  = CS_N && !ld_work && !step && end_xfer;
    assign tcHit  = stepEn && (workCnt == '0);

    assign selMode      = curMode[ch_sel];
    assign workAddrNext = selMode.decrement ? workAddr - ADDR_W'(1) : workAddr + ADDR_W'(1);
    assign wbAddr       = stepEn ? workAddrNext : workAddr;
    assign wbCnt        = stepEn ? workCnt - CNT_W'(1) : workCnt;
    assign mem_addr     = workAddr;
    assign statusByte   = 8'({dreq[LIM-1:0], tcFlags[LIM-1:0]});
    assign data_oe      = rst_n && regRd;

    function automatic logic [7:0] byteOf(input logic [31:0] w, input logic [1:0] p);
        return w[{p, 3'b000} +: 8];
    endfunction

    always_comb begin
        data_o = 8'h00;
        if (regRd) begin
            if (!isGlobal) begin
                if (chValid) begin
                    data_o = isCnt ? byteOf(32'(curCnt[chIdx]), bytePtr)
                                   : byteOf(32'(curAddr[chIdx]), bytePtr);
                end
            end else if (ofs == OFS_CMD) begin
                data_o = statusByte;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gChan
        logic active;
        assign active = (ch_sel == CW'(g));
        dma_chan_regs #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) uRegs (
            .clk       (clk),
            .rst_n     (rst_n),
            .wrAddr    (regWr && !isGlobal && !isCnt && (chIdx == CW'(g))),
            .wrCnt     (regWr && !isGlobal && isCnt && (chIdx == CW'(g))),
            .bytePtr   (bytePtr),
            .wrData    (data_i),
            .wrMode    (regWr && isGlobal && (ofs == OFS_MODE) && (dataChan == CW'(g))),
            .modeIn    (mode_t'(data_i[7:2])),
            .reload    (tcHit && selMode.autoInit && active),
            .writeBack (((tcHit && !selMode.autoInit) || endEn) && active),
            .wbAddr    (wbAddr),
            .wbCnt     (wbCnt),
            .curAddr   (curAddr[g]),
            .curCnt    (curCnt[g]),
            .mode      (curMode[g])
        );
    end

    // Master clear behaves like reset for everything held here; channel storage is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_o   <= '1;
            req_o    <= '0;
            tcFlags  <= '0;
            rot_prio <= 1'b0;
            bytePtr  <= '0;
            workAddr <= '0;
            workCnt  <= '0;
            tc       <= 1'b0;
            mode_o   <= '0;
        end else if (mclr) begin
            mask_o   <= '1;
            req_o    <= '0;
            tcFlags  <= '0;
            rot_prio <= 1'b0;
            bytePtr  <= '0;
            workAddr <= '0;
            workCnt  <= '0;
            tc       <= 1'b0;
            mode_o   <= '0;
        end else begin
            tc     <= tcHit;
            mode_o <= selMode;
            if (chanAccess) begin
                bytePtr <= (bytePtr == 2'(NB - 1)) ? 2'd0 : bytePtr + 2'd1;
            end
            if (regWr && isGlobal) begin
                case (ofs)
                    OFS_CMD:     rot_prio         <= data_i[4];
                    OFS_REQ:     req_o[dataChan]  <= data_i[2];
                    OFS_MASK1:   mask_o[dataChan] <= data_i[2];
                    OFS_CLRPTR:  bytePtr          <= '0;
                    OFS_CLRMASK: mask_o           <= '0;
                    OFS_ALLMASK: mask_o           <= data_i[NUM_CH-1:0];
                    default:     ;
                endcase
            end
            if (regRd && isGlobal && (ofs == OFS_CMD)) begin
                tcFlags <= '0;
            end
            if (ldEn) begin
                workAddr <= curAddr[ch_sel];
                workCnt  <= curCnt[ch_sel];
            end else if (stepEn) begin
                workAddr <= workAddrNext;
                workCnt  <= workCnt - CNT_W'(1);
                if (tcHit) begin
                    tcFlags[ch_sel] <= 1'b1;
                    if (!selMode.autoInit) begin
                        mask_o[ch_sel] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_multichannel_datapath.sv
// Bench for dma_multichannel_datapath: register table, directed transfer cases,
// randomized transfers against an arithmetic model, plus an 8-channel/24-bit instance.
module tb_dma_multichannel_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, CS_N, IOR_N, IOW_N, data_oe, ld_work, step, end_xfer, tc, rot_prio;
    logic [3:0]  port_addr, dreq, mask_o, req_o;
    logic [7:0]  data_i, data_o;
    logic [1:0]  ch_sel;
    logic [15:0] mem_addr;
    logic [5:0]  mode_o;

    logic        cs8, ior8, iow8, oe8, ld8, tc8, rot8;
    logic [4:0]  pa8;
    logic [7:0]  di8, do8, mask8, req8;
    logic [2:0]  sel8;
    logic [23:0] mem8;
    logic [5:0]  mode8;

    int checks = 0;
    int failures = 0;

    dma_multichannel_datapath dut (
        .clk(clk), .rst_n(rst_n), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .port_addr(port_addr), .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
        .ch_sel(ch_sel), .ld_work(ld_work), .step(step), .end_xfer(end_xfer), .dreq(dreq),
        .mem_addr(mem_addr), .tc(tc), .mode_o(mode_o), .mask_o(mask_o), .req_o(req_o),
        .rot_prio(rot_prio)
    );

    dma_multichannel_datapath #(.NUM_CH(8), .ADDR_W(24), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .CS_N(cs8), .IOR_N(ior8), .IOW_N(iow8),
        .port_addr(pa8), .data_i(di8), .data_o(do8), .data_oe(oe8),
        .ch_sel(sel8), .ld_work(ld8), .step(1'b0), .end_xfer(1'b0), .dreq(8'h00),
        .mem_addr(mem8), .tc(tc8), .mode_o(mode8), .mask_o(mask8), .req_o(req8),
        .rot_prio(rot8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic regWr(input logic [3:0] pa, input logic [7:0] d);
        CS_N = 1'b0; IOW_N = 1'b0; port_addr = pa; data_i = d;
        cyc();
        CS_N = 1'b1; IOW_N = 1'b1;
    endtask

    task automatic regRd(input logic [3:0] pa, output logic [7:0] v);
        CS_N = 1'b0; IOR_N = 1'b0; port_addr = pa;
        #1;
        v = data_o;
        check("data_oe", data_oe, 1);
        cyc();
        CS_N = 1'b1; IOR_N = 1'b1;
    endtask

    task automatic readCur(input int ch, input int isCnt, output logic [15:0] v);
        logic [7:0] lo, hi;
        regWr(4'hC, 8'h00);
        regRd(4'(ch * 2 + isCnt), lo);
        regRd(4'(ch * 2 + isCnt), hi);
        v = {hi, lo};
    endtask

    task automatic progChan(input int ch, input logic [15:0] a, input logic [15:0] c,
                            input logic [7:0] modeByte);
        regWr(4'hC, 8'h00);
        regWr(4'(ch * 2), a[7:0]);
        regWr(4'(ch * 2), a[15:8]);
        regWr(4'(ch * 2 + 1), c[7:0]);
        regWr(4'(ch * 2 + 1), c[15:8]);
        regWr(4'hB, modeByte);
        regWr(4'hE, 8'h00);
    endtask

    // Model: after k steps the address is base +/- k and the count is count - k;
    // terminal count fires on step number count+1.
    task automatic runXfer(input int ch, input logic [15:0] a, input logic [15:0] c,
                           input logic autoI, input logic dec, input int n, input logic useEnd);
        logic [7:0]  modeByte, st;
        logic [15:0] v, expA, expC, wantA;
        logic        hit;
        modeByte = {2'b01, dec, autoI, 2'b00, 2'(ch)};
        dreq = 4'($urandom);
        progChan(ch, a, c, modeByte);
        ch_sel = 2'(ch); ld_work = 1'b1;
        cyc();
        ld_work = 1'b0;
        check("ld_addr", mem_addr, a);
        check("mode_o", mode_o, modeByte[7:2]);
        hit = 1'b0;
        wantA = a;
        for (int k = 1; k <= n; k++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            wantA = dec ? a - 16'(k) : a + 16'(k);
            check($sformatf("step%0d_addr", k), mem_addr, wantA);
            check($sformatf("step%0d_tc", k), tc, (k == int'(c) + 1));
            if (k == int'(c) + 1) hit = 1'b1;
        end
        expA = a; expC = c;
        if (hit) begin
            if (!autoI) begin expA = wantA; expC = c - 16'(n); end
        end else if (useEnd) begin
            end_xfer = 1'b1;
            cyc();
            end_xfer = 1'b0;
            expA = wantA; expC = c - 16'(n);
        end
        cyc();
        check("tc_idle", tc, 0);
        check("mask_after", mask_o, (hit && !autoI) ? 4'(1 << ch) : 4'h0);
        regRd(4'h8, st);
        check("status", st, {dreq, hit ? 4'(1 << ch) : 4'h0});
        regRd(4'h8, st);
        check("status_cleared", st, {dreq, 4'h0});
        readCur(ch, 0, v);
        check("cur_addr", v, expA);
        readCur(ch, 1, v);
        check("cur_cnt", v, expC);
    endtask

    task automatic wr8(input logic [4:0] pa, input logic [7:0] d);
        cs8 = 1'b0; iow8 = 1'b0; pa8 = pa; di8 = d;
        cyc();
        cs8 = 1'b1; iow8 = 1'b1;
    endtask

    task automatic rd8(input logic [4:0] pa, input logic [7:0] exp, input string name);
        cs8 = 1'b0; ior8 = 1'b0; pa8 = pa;
        #1;
        check(name, do8, exp);
        cyc();
        cs8 = 1'b1; ior8 = 1'b1;
    endtask

    typedef struct {
        logic       rd;
        logic [3:0] pa;
        logic [7:0] d;
        logic [7:0] expRd;
        logic [3:0] expMask;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [7:0]  v8;
        logic [15:0] v16;
        int c, n;

        tbl[0]  = '{1'b0, 4'hC, 8'h00, 8'h00, 4'hF};
        tbl[1]  = '{1'b0, 4'h4, 8'h34, 8'h00, 4'hF};
        tbl[2]  = '{1'b0, 4'h4, 8'h12, 8'h00, 4'hF};
        tbl[3]  = '{1'b1, 4'h4, 8'h00, 8'h34, 4'hF};
        tbl[4]  = '{1'b1, 4'h4, 8'h00, 8'h12, 4'hF};
        tbl[5]  = '{1'b0, 4'h5, 8'h78, 8'h00, 4'hF};
        tbl[6]  = '{1'b0, 4'h5, 8'h56, 8'h00, 4'hF};
        tbl[7]  = '{1'b1, 4'h5, 8'h00, 8'h78, 4'hF};
        tbl[8]  = '{1'b1, 4'h5, 8'h00, 8'h56, 4'hF};
        tbl[9]  = '{1'b1, 4'h4, 8'h00, 8'h34, 4'hF};
        tbl[10] = '{1'b0, 4'hF, 8'h05, 8'h00, 4'h5};
        tbl[11] = '{1'b1, 4'hD, 8'h00, 8'h00, 4'h5};
        tbl[12] = '{1'b0, 4'hE, 8'h00, 8'h00, 4'h0};
        tbl[13] = '{1'b0, 4'hA, 8'h06, 8'h00, 4'h4};
        tbl[14] = '{1'b0, 4'h9, 8'h05, 8'h00, 4'h4};
        tbl[15] = '{1'b0, 4'h8, 8'h10, 8'h00, 4'h4};

        rst_n = 1'b0; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; port_addr = '0; data_i = '0;
        ch_sel = '0; ld_work = 1'b0; step = 1'b0; end_xfer = 1'b0; dreq = '0;
        cs8 = 1'b1; ior8 = 1'b1; iow8 = 1'b1; pa8 = '0; di8 = '0; sel8 = '0; ld8 = 1'b0;
        repeat (2) cyc();
        check("rst_mask", mask_o, 4'hF);
        check("rst_req", req_o, 4'h0);
        check("rst_tc", tc, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mode", mode_o, 6'h00);
        check("rst_rot", rot_prio, 0);
        check("rst_oe", data_oe, 0);
        check("rst_mask8", mask8, 8'hFF);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rd) begin
                regRd(tbl[i].pa, v8);
                check($sformatf("tbl%0d_rd", i), v8, tbl[i].expRd);
            end else begin
                regWr(tbl[i].pa, tbl[i].d);
            end
            check($sformatf("tbl%0d_mask", i), mask_o, tbl[i].expMask);
        end
        check("req_after_tbl", req_o, 4'b0010);
        check("rot_after_tbl", rot_prio, 1);

        regWr(4'hD, 8'h00);
        check("mclr_mask", mask_o, 4'hF);
        check("mclr_req", req_o, 4'h0);
        check("mclr_rot", rot_prio, 0);
        readCur(2, 0, v16);
        check("mclr_keeps_addr", v16, 16'h1234);
        readCur(2, 1, v16);
        check("mclr_keeps_cnt", v16, 16'h5678);

        // 8-channel, 24-bit address instance: three-byte pointer span
        wr8(5'b10100, 8'h00);
        wr8(5'b01010, 8'h56);
        wr8(5'b01010, 8'h34);
        wr8(5'b01010, 8'h12);
        rd8(5'b01010, 8'h56, "ch5_b0");
        rd8(5'b01010, 8'h34, "ch5_b1");
        rd8(5'b01010, 8'h12, "ch5_b2");
        rd8(5'b01010, 8'h56, "ch5_wrap");
        sel8 = 3'd5; ld8 = 1'b1;
        cyc();
        ld8 = 1'b0;
        check("ch5_mem_addr", mem8, 24'h123456);
        wr8(5'b10100, 8'h00);
        wr8(5'b01011, 8'hAA);
        wr8(5'b01011, 8'hBB);
        wr8(5'b01011, 8'hCC);
        rd8(5'b01011, 8'hAA, "ch5_cnt_b0");
        rd8(5'b01011, 8'hBB, "ch5_cnt_b1");
        rd8(5'b01011, 8'h00, "ch5_cnt_beyond");

        // Increment, no auto-init: TC on third step, channel masks itself
        runXfer(0, 16'h0100, 16'h0002, 1'b0, 1'b0, 3, 1'b0);
        check("req021_mem", mem_addr, 16'h0103);
        // Decrement with auto-init: current reloads, mask stays clear
        runXfer(0, 16'h0100, 16'h0002, 1'b1, 1'b1, 3, 1'b0);
        check("req022_mem", mem_addr, 16'h00FD);
        // Early end of service writes back partial progress
        runXfer(3, 16'hFFFE, 16'h0005, 1'b0, 1'b0, 3, 1'b1);

        for (int it = 0; it < 20; it++) begin
            c = $urandom_range(0, 4);
            n = $urandom_range(1, c + 1);
            runXfer($urandom_range(0, 3), 16'($urandom), 16'(c), 1'($urandom), 1'($urandom),
                    n, 1'($urandom));
        end

        // Transfer controls ignored while selected; ld_work beats step
        progChan(1, 16'h2000, 16'h0010, 8'h41);
        ch_sel = 2'd1; ld_work = 1'b1;
        cyc();
        ld_work = 1'b0;
        CS_N = 1'b0; step = 1'b1;
        cyc();
        CS_N = 1'b1; step = 1'b0;
        check("step_cs_low", mem_addr, 16'h2000);
        ld_work = 1'b1; step = 1'b1;
        cyc();
        ld_work = 1'b0; step = 1'b0;
        check("ld_over_step", mem_addr, 16'h2000);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_before_rst", mem_addr, 16'h2001);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mask", mask_o, 4'hF);
        check("midrst_mem", mem_addr, 16'h0000);
        #1 rst_n = 1'b1;
        cyc();
        check("post_rst_idle", mem_addr, 16'h0000);
        check("post_rst_tc", tc, 0);
        readCur(1, 0, v16);
        check("post_rst_cur_addr", v16, 16'h0000);
        readCur(1, 1, v16);
        check("post_rst_cur_cnt", v16, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
